// File: rtl/cluster_frame_tx_if.sv
// Bundles the cluster-set load bus and the framed word-pair outputs of cluster_frame_tx.
// The master modport belongs to the cluster sorter; the slave modport belongs to the frame transmitter.
interface cluster_frame_tx_if #(
  parameter int MXADRBITS = 11,
  parameter int MXCNTBITS = 3
);
  logic                           load_i;
  logic                           bc0_i;
  logic [MXADRBITS-1:0]           adr0_i, adr1_i, adr2_i, adr3_i;
  logic [MXADRBITS-1:0]           adr4_i, adr5_i, adr6_i, adr7_i;
  logic [MXCNTBITS-1:0]           cnt0_i, cnt1_i, cnt2_i, cnt3_i;
  logic [MXCNTBITS-1:0]           cnt4_i, cnt5_i, cnt6_i, cnt7_i;
  logic [MXCNTBITS+MXADRBITS-1:0] tx_word0_o, tx_word1_o;
  logic [1:0]                     tx_valid_o;
  logic                           frame_o;
  logic                           busy_o;
  logic [11:0]                    bxn_o;
  logic [3:0]                     n_clusters_o;
  logic                           sort_err_o;
  logic                           overflow_o;
  logic [7:0]                     ovf_cnt_o;

  modport master (
    output load_i, bc0_i,
    output adr0_i, adr1_i, adr2_i, adr3_i, adr4_i, adr5_i, adr6_i, adr7_i,
    output cnt0_i, cnt1_i, cnt2_i, cnt3_i, cnt4_i, cnt5_i, cnt6_i, cnt7_i,
    input  tx_word0_o, tx_word1_o, tx_valid_o, frame_o, busy_o,
    input  bxn_o, n_clusters_o, sort_err_o, overflow_o, ovf_cnt_o
  );

  modport slave (
    input  load_i, bc0_i,
    input  adr0_i, adr1_i, adr2_i, adr3_i, adr4_i, adr5_i, adr6_i, adr7_i,
    input  cnt0_i, cnt1_i, cnt2_i, cnt3_i, cnt4_i, cnt5_i, cnt6_i, cnt7_i,
    output tx_word0_o, tx_word1_o, tx_valid_o, frame_o, busy_o,
    output bxn_o, n_clusters_o, sort_err_o, overflow_o, ovf_cnt_o
  );
endinterface

// File: rtl/cluster_frame_tx.sv
// Serialises one sorted 8-cluster set into four {cnt,adr} word pairs, one pair per 4x clock,
// tagging each frame with its bunch-crossing number, cluster count and a sort-order check.
module cluster_frame_tx #(
  parameter int                   MXADRBITS   = 11,
  parameter int                   MXCNTBITS   = 3,
  parameter logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF,
  parameter int                   BX_MAX      = 3564
) (
  input logic               clock4x,
  input logic               reset,
  cluster_frame_tx_if.slave bus
);
  localparam int WW = MXCNTBITS + MXADRBITS;

  typedef enum logic {IDLE, SEND} state_t;

  logic [MXADRBITS-1:0] adr_in [8];
  logic [MXCNTBITS-1:0] cnt_in [8];

  assign adr_in[0] = bus.adr0_i;
  assign adr_in[1] = bus.adr1_i;
  assign adr_in[2] = bus.adr2_i;
  assign adr_in[3] = bus.adr3_i;
  assign adr_in[4] = bus.adr4_i;
  assign adr_in[5] = bus.adr5_i;
  assign adr_in[6] = bus.adr6_i;
  assign adr_in[7] = bus.adr7_i;
  assign cnt_in[0] = bus.cnt0_i;
  assign cnt_in[1] = bus.cnt1_i;
  assign cnt_in[2] = bus.cnt2_i;
  assign cnt_in[3] = bus.cnt3_i;
  assign cnt_in[4] = bus.cnt4_i;
  assign cnt_in[5] = bus.cnt5_i;
  assign cnt_in[6] = bus.cnt6_i;
  assign cnt_in[7] = bus.cnt7_i;

  state_t               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [MXADRBITS-1:0] adr_q [8];
  logic [MXADRBITS-1:0] adr_d [8];
  logic [MXCNTBITS-1:0] cnt_q [8];
  logic [MXCNTBITS-1:0] cnt_d [8];
  logic [11:0]          bx_cnt_q, bx_cnt_d;
  logic [11:0]          bxn_q, bxn_d;
  logic [3:0]           n_clusters_q, n_clusters_d;
  logic                 sort_err_q, sort_err_d;
  logic [WW-1:0]        word0_q, word0_d;
  logic [WW-1:0]        word1_q, word1_d;
  logic [1:0]           valid_q, valid_d;
  logic                 frame_q, frame_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           ovf_cnt_q, ovf_cnt_d;

  logic                 accept;
  logic                 drop;
  logic [3:0]           n_valid;
  logic                 unsorted;
  logic [2:0]           slot_lo;
  logic [2:0]           slot_hi;

  // Empty slots go out as {0, INVALID_ADR} whatever count accompanied them.
  function automatic logic [WW-1:0] slot_word(input logic [MXADRBITS-1:0] adr,
                                              input logic [MXCNTBITS-1:0] cnt);
    return (adr == INVALID_ADR) ? {{MXCNTBITS{1'b0}}, INVALID_ADR} : {cnt, adr};
  endfunction

  always_comb begin
    n_valid  = '0;
    unsorted = 1'b0;
    for (int i = 0; i < 8; i++)
      if (adr_in[i] != INVALID_ADR) n_valid = n_valid + 4'd1;
    for (int i = 0; i < 7; i++)
      if (adr_in[i] > adr_in[i+1]) unsorted = 1'b1;
  end

  // Outputs are registered one phase ahead: accepting a load already forms the phase-0 pair.
  always_comb begin
    accept       = bus.load_i && (state_q == IDLE || phase_q == 2'd3);
    drop         = bus.load_i && !accept;
    state_d      = state_q;
    phase_d      = phase_q;
    adr_d        = adr_q;
    cnt_d        = cnt_q;
    bx_cnt_d     = bus.bc0_i ? 12'd0 : bx_cnt_q;
    bxn_d        = bxn_q;
    n_clusters_d = n_clusters_q;
    sort_err_d   = sort_err_q;
    word0_d      = '0;
    word1_d      = '0;
    valid_d      = 2'b00;
    frame_d      = 1'b0;
    busy_d       = 1'b0;
    overflow_d   = drop;
    ovf_cnt_d    = (drop && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
    slot_lo      = '0;
    slot_hi      = '0;

    if (accept) begin
      state_d      = SEND;
      phase_d      = 2'd0;
      adr_d        = adr_in;
      cnt_d        = cnt_in;
      bxn_d        = bus.bc0_i ? 12'd0 : bx_cnt_q;
      bx_cnt_d     = (bxn_d == 12'(BX_MAX - 1)) ? 12'd0 : bxn_d + 12'd1;
      n_clusters_d = n_valid;
      sort_err_d   = unsorted;
      word0_d      = slot_word(adr_in[0], cnt_in[0]);
      word1_d      = slot_word(adr_in[1], cnt_in[1]);
      valid_d      = {adr_in[1] != INVALID_ADR, adr_in[0] != INVALID_ADR};
      frame_d      = 1'b1;
      busy_d       = 1'b1;
    end else if (state_q == SEND && phase_q != 2'd3) begin
      phase_d = phase_q + 2'd1;
      slot_lo = {phase_d, 1'b0};
      slot_hi = {phase_d, 1'b1};
      word0_d = slot_word(adr_q[slot_lo], cnt_q[slot_lo]);
      word1_d = slot_word(adr_q[slot_hi], cnt_q[slot_hi]);
      valid_d = {adr_q[slot_hi] != INVALID_ADR, adr_q[slot_lo] != INVALID_ADR};
      busy_d  = 1'b1;
    end else if (state_q == SEND) begin
      state_d = IDLE;
      phase_d = 2'd0;
    end
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      adr_q        <= '{default: '0};
      cnt_q        <= '{default: '0};
      bx_cnt_q     <= '0;
      bxn_q        <= '0;
      n_clusters_q <= '0;
      sort_err_q   <= 1'b0;
      word0_q      <= '0;
      word1_q      <= '0;
      valid_q      <= '0;
      frame_q      <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      adr_q        <= adr_d;
      cnt_q        <= cnt_d;
      bx_cnt_q     <= bx_cnt_d;
      bxn_q        <= bxn_d;
      n_clusters_q <= n_clusters_d;
      sort_err_q   <= sort_err_d;
      word0_q      <= word0_d;
      word1_q      <= word1_d;
      valid_q      <= valid_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign bus.tx_word0_o   = word0_q;
  assign bus.tx_word1_o   = word1_q;
  assign bus.tx_valid_o   = valid_q;
  assign bus.frame_o      = frame_q;
  assign bus.busy_o       = busy_q;
  assign bus.bxn_o        = bxn_q;
  assign bus.n_clusters_o = n_clusters_q;
  assign bus.sort_err_o   = sort_err_q;
  assign bus.overflow_o   = overflow_q;
  assign bus.ovf_cnt_o    = ovf_cnt_q;
endmodule

// File: tb/tb_cluster_frame_tx.sv
// Directed bench for cluster_frame_tx: a cycle-by-cycle vector table for framing, overflow and
// bc0 handling, followed by hand sequences for counter saturation, mid-frame reset and bx wrap.
module tb_cluster_frame_tx;
  localparam logic [13:0] INV = 14'h07FF;

  logic clock4x = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cluster_frame_tx_if bus ();

  cluster_frame_tx dut (
    .clock4x (clock4x),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock4x = ~clock4x;

  typedef struct {
    string       name;
    logic        load;
    logic        bc0;
    int          pat;
    logic [13:0] w0;
    logic [13:0] w1;
    logic [1:0]  valid;
    logic        frame;
    logic        busy;
    logic [3:0]  ncl;
    logic        serr;
    logic        ovf;
    logic [11:0] bxn;
    logic [7:0]  ovfc;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] patAdr [4][8];
  logic [2:0]  patCnt [4][8];

  function automatic vec_t mk(string name, logic load, logic bc0, int pat,
                              logic [13:0] w0, logic [13:0] w1, logic [1:0] valid,
                              logic frame, logic busy, logic [3:0] ncl, logic serr,
                              logic ovf, logic [11:0] bxn, logic [7:0] ovfc);
    vec_t v;
    v.name = name; v.load = load; v.bc0 = bc0; v.pat = pat;
    v.w0 = w0; v.w1 = w1; v.valid = valid; v.frame = frame; v.busy = busy;
    v.ncl = ncl; v.serr = serr; v.ovf = ovf; v.bxn = bxn; v.ovfc = ovfc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  task automatic applyStimulus(input logic load, input logic bc0, input int pat);
    bus.load_i = load;
    bus.bc0_i  = bc0;
    bus.adr0_i = patAdr[pat][0]; bus.cnt0_i = patCnt[pat][0];
    bus.adr1_i = patAdr[pat][1]; bus.cnt1_i = patCnt[pat][1];
    bus.adr2_i = patAdr[pat][2]; bus.cnt2_i = patCnt[pat][2];
    bus.adr3_i = patAdr[pat][3]; bus.cnt3_i = patCnt[pat][3];
    bus.adr4_i = patAdr[pat][4]; bus.cnt4_i = patCnt[pat][4];
    bus.adr5_i = patAdr[pat][5]; bus.cnt5_i = patCnt[pat][5];
    bus.adr6_i = patAdr[pat][6]; bus.cnt6_i = patCnt[pat][6];
    bus.adr7_i = patAdr[pat][7]; bus.cnt7_i = patCnt[pat][7];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input vec_t v);
    checkOutput({v.name, "/word0"},    32'(bus.tx_word0_o),   32'(v.w0));
    checkOutput({v.name, "/word1"},    32'(bus.tx_word1_o),   32'(v.w1));
    checkOutput({v.name, "/valid"},    32'(bus.tx_valid_o),   32'(v.valid));
    checkOutput({v.name, "/frame"},    32'(bus.frame_o),      32'(v.frame));
    checkOutput({v.name, "/busy"},     32'(bus.busy_o),       32'(v.busy));
    checkOutput({v.name, "/nclu"},     32'(bus.n_clusters_o), 32'(v.ncl));
    checkOutput({v.name, "/sort_err"}, 32'(bus.sort_err_o),   32'(v.serr));
    checkOutput({v.name, "/overflow"}, 32'(bus.overflow_o),   32'(v.ovf));
    checkOutput({v.name, "/bxn"},      32'(bus.bxn_o),        32'(v.bxn));
    checkOutput({v.name, "/ovf_cnt"},  32'(bus.ovf_cnt_o),    32'(v.ovfc));
  endtask

  initial begin
    // Pattern 0: four clusters; 1: descending pair with junk counts on empty slots;
    // 2: all empty; 3: eight equal addresses.
    patAdr[0] = '{11'd1, 11'd5, 11'd9, 11'd20, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
    patCnt[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    patAdr[1] = '{11'd50, 11'd10, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
    patCnt[1] = '{3'd2, 3'd5, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    patAdr[2] = '{default: 11'h7FF};
    patCnt[2] = '{default: 3'd1};
    patAdr[3] = '{default: 11'd3};
    patCnt[3] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    //                  name        ld bc pat  word0     word1     v  f  b  ncl sre ovf bxn ovfc
    vecs.push_back(mk("idle",       0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("A.p0",       1, 0, 0, 14'h0801, 14'h1005, 3, 1, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("A.p1",       0, 0, 0, 14'h1809, 14'h2014, 3, 0, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("A.p2",       0, 0, 0, INV,      INV,      0, 0, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("A.p3",       0, 0, 0, INV,      INV,      0, 0, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("D.p0.b2b",   1, 0, 3, 14'h0003, 14'h0803, 3, 1, 1, 8, 0, 0, 1, 0));
    vecs.push_back(mk("D.p1",       0, 0, 0, 14'h1003, 14'h1803, 3, 0, 1, 8, 0, 0, 1, 0));
    vecs.push_back(mk("D.p2.drop",  1, 0, 1, 14'h2003, 14'h2803, 3, 0, 1, 8, 0, 1, 1, 1));
    vecs.push_back(mk("D.p3",       0, 0, 0, 14'h3003, 14'h3803, 3, 0, 1, 8, 0, 0, 1, 1));
    vecs.push_back(mk("idle.held",  0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 8, 0, 0, 1, 1));
    vecs.push_back(mk("B.p0.bc0",   1, 1, 1, 14'h1032, 14'h280A, 3, 1, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk("B.p1",       0, 0, 0, INV,      INV,      0, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk("B.p2",       0, 0, 0, INV,      INV,      0, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk("B.p3",       0, 0, 0, INV,      INV,      0, 0, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk("C.p0",       1, 0, 2, INV,      INV,      0, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("C.p1",       0, 0, 0, INV,      INV,      0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("C.p2",       0, 0, 0, INV,      INV,      0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("C.p3",       0, 0, 0, INV,      INV,      0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("idle.C",     0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("bc0.idle",   0, 1, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("A2.p0",      1, 0, 0, 14'h0801, 14'h1005, 3, 1, 1, 4, 0, 0, 0, 1));
    vecs.push_back(mk("A2.drop.bc0",1, 1, 1, 14'h1809, 14'h2014, 3, 0, 1, 4, 0, 1, 0, 2));
    vecs.push_back(mk("A2.p2",      0, 0, 0, INV,      INV,      0, 0, 1, 4, 0, 0, 0, 2));
    vecs.push_back(mk("A2.p3",      0, 0, 0, INV,      INV,      0, 0, 1, 4, 0, 0, 0, 2));
    vecs.push_back(mk("A3.p0",      1, 0, 0, 14'h0801, 14'h1005, 3, 1, 1, 4, 0, 0, 0, 2));
    vecs.push_back(mk("A3.p1",      0, 0, 0, 14'h1809, 14'h2014, 3, 0, 1, 4, 0, 0, 0, 2));
    vecs.push_back(mk("A3.p2",      0, 0, 0, INV,      INV,      0, 0, 1, 4, 0, 0, 0, 2));
    vecs.push_back(mk("A3.p3",      0, 0, 0, INV,      INV,      0, 0, 1, 4, 0, 0, 0, 2));
    vecs.push_back(mk("idle.A3",    0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 4, 0, 0, 0, 2));

    reset = 1'b1;
    applyStimulus(0, 0, 0);
    tick();
    tick();
    checkAll(mk("reset", 0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].load, vecs[i].bc0, vecs[i].pat);
      tick();
      checkAll(vecs[i]);
    end

    // Continuous load: three of every four loads are dropped until the counter saturates.
    for (int i = 0; i < 440; i++) begin
      applyStimulus(1, 0, 0);
      tick();
    end
    checkOutput("sat/ovf_cnt", 32'(bus.ovf_cnt_o), 32'd255);
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("sat/drain_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("sat/ovf_hold", 32'(bus.ovf_cnt_o), 32'd255);

    // Reset while phase 1 is on the outputs, with a load and bc0 offered at the same edge.
    applyStimulus(1, 0, 3);
    tick();
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("midrst/pre_phase1", 32'(bus.tx_word0_o), 32'h1003);
    reset = 1'b1;
    applyStimulus(1, 1, 0);
    tick();
    checkAll(mk("midrst", 0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("midrst/no_tail_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("midrst/no_tail_valid", 32'(bus.tx_valid_o), 32'd0);
    applyStimulus(1, 0, 0);
    tick();
    checkOutput("midrst/first_bxn", 32'(bus.bxn_o), 32'd0);
    checkOutput("midrst/first_frame", 32'(bus.frame_o), 32'd1);
    checkOutput("midrst/first_word0", 32'(bus.tx_word0_o), 32'h0801);
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    // Bunch-crossing numbering across a full orbit and its wrap to zero.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i <= 3564; i++) begin
      applyStimulus(1, 0, 0);
      tick();
      checkOutput($sformatf("wrap/bxn%0d", i), 32'(bus.bxn_o), 32'(i % 3564));
      applyStimulus(0, 0, 0);
      tick();
      tick();
      tick();
    end
    checkOutput("wrap/no_overflow", 32'(bus.ovf_cnt_o), 32'd0);
    tick();
    checkOutput("wrap/idle_busy", 32'(bus.busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
